// File: rtl/timer_cnt_ctrl_pkg.sv
// timer_cnt_ctrl_pkg: shared state encoding and sizing for the timer counter block
package timer_cnt_ctrl_pkg;
  localparam int CNT_W = 64;
  localparam int DIV_W = 4;
  localparam int DIV_MAX = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: power-of-two prescaler with divisor clamp and settings change detect
module timer_prescaler #(
  parameter int DIV_W = timer_cnt_ctrl_pkg::DIV_W,
  parameter int DIV_MAX = timer_cnt_ctrl_pkg::DIV_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);
  logic [DIV_MAX-1:0] ps, term;
  logic [DIV_W-1:0] prev_val, eff;
  logic prev_en, chg;
  always_comb begin
    eff = (int'(div_val) > DIV_MAX) ? DIV_W'(DIV_MAX) : div_val;
    term = ~({DIV_MAX{1'b1}} << eff);
    chg = {div_en, div_val} != {prev_en, prev_val};
    tick = run && !chg && (!div_en || ps == term);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= '0;
      prev_en <= 1'b0;
      prev_val <= '0;
    end else begin
      prev_en <= div_en;
      prev_val <= div_val;
      ps <= (clr || chg || tick || !div_en) ? '0 : run ? ps + 1'b1 : ps;
    end
  end
endmodule

// File: rtl/timer_cnt_ctrl.sv
// timer_cnt_ctrl: 64-bit timer counter with run/halt FSM, prescaler and byte-masked writes
module timer_cnt_ctrl #(
  parameter int CNT_W = timer_cnt_ctrl_pkg::CNT_W,
  parameter int DIV_W = timer_cnt_ctrl_pkg::DIV_W,
  parameter int DIV_MAX = timer_cnt_ctrl_pkg::DIV_MAX
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             dbg_mode,
  input  logic             halt_req,
  input  logic             cnt_lo_we,
  input  logic             cnt_hi_we,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_tick,
  output logic             cnt_ovf,
  output logic             halt_ack,
  output logic [1:0]       state
);
  import timer_cnt_ctrl_pkg::*;
  state_t st;
  logic run, clr, we;
  logic [CNT_W-1:0] base, nxt;
  assign state = st;
  assign run = st == RUN;
  assign clr = st != IDLE && !timer_en;
  assign we = cnt_lo_we || cnt_hi_we;
  timer_prescaler #(.DIV_W(DIV_W), .DIV_MAX(DIV_MAX)) u_pre (
    .clk(sys_clk), .rst(sys_rst), .run(run), .clr(clr),
    .div_en(div_en), .div_val(div_val), .tick(cnt_tick)
  );
  // any write blocks the increment so no carry crosses a written half
  always_comb begin
    base = clr ? '0 : cnt;
    nxt = (cnt_tick && !clr && !we) ? cnt + 1'b1 : base;
    for (int b = 0; b < CNT_W / 8; b++)
      if (((b < 4) ? cnt_lo_we : cnt_hi_we) && wstrb[b % 4]) nxt[8*b +: 8] = wdata[8*(b % 4) +: 8];
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st <= IDLE;
      cnt <= '0;
      cnt_ovf <= 1'b0;
      halt_ack <= 1'b0;
    end else begin
      cnt <= nxt;
      cnt_ovf <= cnt_tick && !clr && !we && &cnt;
      if (clr) begin
        st <= IDLE;
        halt_ack <= 1'b0;
      end else if (st == IDLE && timer_en) st <= RUN;
      else if (st == RUN && dbg_mode && halt_req) begin
        st <= HALT;
        halt_ack <= 1'b1;
      end else if (st == HALT && !halt_req) begin
        st <= RUN;
        halt_ack <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// tb_timer_cnt_ctrl: directed self-checking bench for timer_cnt_ctrl
module tb_timer_cnt_ctrl;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic timer_en = 1'b0, div_en = 1'b0, dbg_mode = 1'b0, halt_req = 1'b0;
  logic cnt_lo_we = 1'b0, cnt_hi_we = 1'b0;
  logic [3:0] div_val = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic [63:0] cnt;
  logic cnt_tick, cnt_ovf, halt_ack;
  logic [1:0] state;
  int n_cmp = 0, n_bad = 0, ticks, first;

  timer_cnt_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .timer_en(timer_en), .div_en(div_en),
    .div_val(div_val), .dbg_mode(dbg_mode), .halt_req(halt_req),
    .cnt_lo_we(cnt_lo_we), .cnt_hi_we(cnt_hi_we), .wdata(wdata), .wstrb(wstrb),
    .cnt(cnt), .cnt_tick(cnt_tick), .cnt_ovf(cnt_ovf), .halt_ack(halt_ack), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic to_idle();
    timer_en = 1'b0; div_en = 1'b0; div_val = '0;
    cyc(1);
  endtask

  initial begin
    cyc(2);
    sys_rst = 1'b0;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cnt", cnt, 64'd0);
    chk("rst_tick", 64'(cnt_tick), 64'd0);
    chk("rst_ovf", 64'(cnt_ovf), 64'd0);
    chk("rst_hack", 64'(halt_ack), 64'd0);
    // first tick latency and undivided counting
    timer_en = 1'b1;
    #1 chk("idle_tick", 64'(cnt_tick), 64'd0);
    cyc(1);
    chk("run_state", 64'(state), 64'd1);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      if (cnt_tick) ticks++;
      cyc(1);
    end
    chk("nodiv_ticks", 64'(ticks), 64'd10);
    chk("nodiv_cnt", cnt, 64'd10);
    to_idle();
    chk("exit_cnt", cnt, 64'd0);
    chk("exit_state", 64'(state), 64'd0);
    // divide by 8
    div_en = 1'b1; div_val = 4'd3; timer_en = 1'b1;
    cyc(1);
    ticks = 0; first = -1;
    for (int k = 0; k < 32; k++) begin
      if (cnt_tick) begin
        if (first < 0) first = k;
        else chk("div8_spacing", 64'(k - first - 8 * ticks), 64'd0);
        ticks++;
      end
      cyc(1);
    end
    chk("div8_ticks", 64'(ticks), 64'd4);
    chk("div8_first", 64'(first), 64'd7);
    chk("div8_cnt", cnt, 64'd4);
    to_idle();
    // div_val above DIV_MAX clamps to 256-cycle period
    div_en = 1'b1; div_val = 4'd15; timer_en = 1'b1;
    cyc(1);
    ticks = 0; first = -1;
    for (int k = 0; k < 256; k++) begin
      if (cnt_tick) begin
        if (first < 0) first = k;
        ticks++;
      end
      cyc(1);
    end
    chk("clamp_ticks", 64'(ticks), 64'd1);
    chk("clamp_first", 64'(first), 64'd255);
    to_idle();
    // changing the divisor clears the prescaler and suppresses the tick
    div_en = 1'b1; div_val = 4'd2; timer_en = 1'b1;
    cyc(2);
    chk("chg_pre", 64'(cnt_tick), 64'd0);
    div_val = 4'd1;
    #1 chk("chg_sup", 64'(cnt_tick), 64'd0);
    cyc(1);
    chk("chg_clr", 64'(cnt_tick), 64'd0);
    cyc(1);
    chk("chg_tick", 64'(cnt_tick), 64'd1);
    to_idle();
    // wrap and overflow pulse
    cnt_lo_we = 1'b1; cnt_hi_we = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    cyc(1);
    cnt_lo_we = 1'b0; cnt_hi_we = 1'b0;
    chk("ones_cnt", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ones_state", 64'(state), 64'd0);
    timer_en = 1'b1;
    cyc(1);
    chk("wrap_ovf0", 64'(cnt_ovf), 64'd0);
    cyc(1);
    chk("wrap_cnt", cnt, 64'd0);
    chk("wrap_ovf1", 64'(cnt_ovf), 64'd1);
    cyc(1);
    chk("wrap_ovf2", 64'(cnt_ovf), 64'd0);
    chk("wrap_cnt1", cnt, 64'd1);
    // halt with cnt written to 100
    cnt_lo_we = 1'b1; wdata = 32'd100; wstrb = 4'hF; dbg_mode = 1'b1; halt_req = 1'b1;
    cyc(1);
    cnt_lo_we = 1'b0;
    chk("halt_state", 64'(state), 64'd2);
    chk("halt_tick", 64'(cnt_tick), 64'd0);
    cyc(5);
    chk("halt_ack", 64'(halt_ack), 64'd1);
    chk("halt_cnt", cnt, 64'd100);
    halt_req = 1'b0;
    cyc(1);
    chk("resume_state", 64'(state), 64'd1);
    chk("resume_ack", 64'(halt_ack), 64'd0);
    cyc(1);
    chk("resume_cnt", cnt, 64'd101);
    // high-half write during a tick leaves low half unincremented
    cnt_hi_we = 1'b1; wdata = 32'h1234_5678; wstrb = 4'b0101; dbg_mode = 1'b0;
    cyc(1);
    cnt_hi_we = 1'b0;
    chk("hi_wr", cnt, 64'h0034_0078_0000_0065);
    // both halves written together
    cnt_lo_we = 1'b1; cnt_hi_we = 1'b1; wdata = 32'd50; wstrb = 4'hF;
    cyc(1);
    chk("both_wr", cnt, 64'h0000_0032_0000_0032);
    cnt_lo_we = 1'b0; wdata = 32'd0;
    cyc(1);
    cnt_hi_we = 1'b0;
    chk("cnt50", cnt, 64'd50);
    // write beats clear on exit to IDLE
    timer_en = 1'b0; cnt_lo_we = 1'b1; wdata = 32'd7; wstrb = 4'h1;
    cyc(1);
    cnt_lo_we = 1'b0;
    chk("exitwr_cnt", cnt, 64'd7);
    chk("exitwr_state", 64'(state), 64'd0);
    // reset overrides a concurrent write mid-run
    timer_en = 1'b1; cnt_lo_we = 1'b1; wdata = 32'd1234; wstrb = 4'hF;
    cyc(1);
    cnt_lo_we = 1'b0;
    chk("pre_rst_cnt", cnt, 64'd1234);
    cyc(3);
    chk("pre_rst_run", cnt, 64'd1237);
    sys_rst = 1'b1; cnt_lo_we = 1'b1; wdata = 32'd55;
    cyc(1);
    chk("mid_rst_cnt", cnt, 64'd0);
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_tick", 64'(cnt_tick), 64'd0);
    sys_rst = 1'b0; cnt_lo_we = 1'b0; timer_en = 1'b0;
    cyc(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timer_cnt_ctrl.md
TIMER_CNT_CTRL -- requirements
Module: timer_cnt_ctrl

Interface
REQ-001 Parameter CNT_W, 64, counter width.
REQ-002 Parameter DIV_W, 4, divisor field width.
REQ-003 Parameter DIV_MAX, 8, largest legal div_val.
REQ-004 Clock and reset SHALL be one clock and a synchronous, active-high reset, on the ports below.
REQ-005 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 sys_rst  input  1  reset, synchronous, active-high.
REQ-007 timer_en  input  1  counter enable from control register bit 0.
REQ-008 div_en  input  1  prescaler enable from control register bit 1.
REQ-009 div_val  input  DIV_W  prescaler exponent from control register [11:8].
REQ-010 dbg_mode  input  1  debug-mode qualifier for halt.
REQ-011 halt_req  input  1  debug halt request, level.
REQ-012 cnt_lo_we  input  1  software write strobe, counter bits [31:0].
REQ-013 cnt_hi_we  input  1  software write strobe, counter bits [63:32].
REQ-014 wdata  input  32  software write data.
REQ-015 wstrb  input  4  byte enables for wdata.
REQ-016 cnt  output  CNT_W  current counter value, registered.
REQ-017 cnt_tick  output  1  combinational pulse; cnt increments at the next edge.
REQ-018 cnt_ovf  output  1  one-cycle registered pulse after cnt wraps all-ones to zero.
REQ-019 halt_ack  output  1  registered; high while in HALT.
REQ-020 state  output  2  FSM state: IDLE=0, RUN=1, HALT=2.

Function
REQ-021 FSM SHALL move IDLE->RUN when timer_en=1.
REQ-022 FSM SHALL move RUN->HALT when dbg_mode=1 and halt_req=1, and HALT->RUN when halt_req=0.
REQ-023 FSM SHALL move RUN->IDLE or HALT->IDLE when timer_en=0; this takes priority over halt transitions.
REQ-024 On every RUN/HALT->IDLE transition, cnt and the prescaler count SHALL clear to 0 at that edge.
REQ-025 Prescaler count SHALL advance only in RUN; HALT and IDLE freeze it.
REQ-026 In RUN with div_en=0, cnt_tick SHALL be 1 every cycle.
REQ-027 In RUN with div_en=1, cnt_tick SHALL be 1 when prescaler count equals 2^div_val-1; that edge resets the prescaler to 0.
REQ-028 div_val>DIV_MAX SHALL be treated as DIV_MAX.
REQ-029 Any change of {div_en,div_val} between consecutive cycles SHALL clear the prescaler count and suppress that cycle's tick.
REQ-030 cnt SHALL increment by 1 modulo 2^CNT_W on an edge where cnt_tick=1.
REQ-031 All-ones cnt wrapping to 0 SHALL assert cnt_ovf in the following cycle only.
REQ-032 Software writes SHALL update only the bytes enabled by wstrb, in any state.
REQ-033 Priority per edge, highest first: software write, then clear on exit to IDLE, then increment.
REQ-034 A write to one half with a concurrent tick SHALL leave the other half unincremented (no carry across a written half).
REQ-035 With cnt_lo_we and cnt_hi_we both high, both halves SHALL take wdata under the same wstrb.
REQ-036 First tick latency: timer_en rises before edge N -> state=RUN after N -> cnt_tick high in cycle N+1 when div_en=0.

Reset
REQ-037 sys_rst=1 at an edge SHALL set state=IDLE, cnt=0, prescaler=0, cnt_ovf=0, halt_ack=0, and stored previous divisor settings to 0.
REQ-038 Reset SHALL override all inputs, including write strobes, mid-operation.
REQ-039 cnt_tick SHALL be 0 while state=IDLE, including the cycle after reset.

Structure
REQ-040 A shared package SHALL hold the state encoding, CNT_W, DIV_W, and DIV_MAX.
REQ-041 The prescaler (count, terminal compare, clamp, change-detect) SHALL be one sub-module, timer_prescaler.

Verification
REQ-042 timer_en=1, div_en=0, for 10 cycles -> cnt=9 or 10 per REQ-036, ticks every cycle.
REQ-043 div_en=1, div_val=3, RUN for 32 cycles -> exactly 4 ticks spaced 8 cycles apart.
REQ-044 cnt_lo_we=cnt_hi_we=1, wdata=FFFF_FFFF, wstrb=F, then one tick -> cnt=0, cnt_ovf high for one cycle.
REQ-045 RUN with cnt=100, dbg_mode=1 and halt_req=1 for 5 cycles -> halt_ack=1, cnt=100 held; halt_req=0 -> counting resumes.
REQ-046 RUN with cnt=50, then timer_en=0 with a concurrent cnt_lo_we, wdata=7, wstrb=1 -> cnt=7, state=IDLE.
REQ-047 sys_rst=1 while RUN with cnt=1234 -> cnt=0, state=IDLE at that edge.
